// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bit levels and a small
// majority helper used by the optional line glitch filter.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2cState_t;

    localparam logic cAck  = 1'b0;
    localparam logic cNack = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN), and SCL edge / START / STOP detection.
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic iClk,
    input  logic iRstN,
    input  logic iScl,
    input  logic iSda,
    output logic oSdaLvl,
    output logic oSclRise,
    output logic oSclFall,
    output logic oStart,
    output logic oStop
);

    logic [1:0] sclSync;
    logic [1:0] sdaSync;
    logic       sclLvl;
    logic       sdaLvl;
    logic       sclPrev;
    logic       sdaPrev;

    // Idle bus level is high, so every stage resets to 1.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            sclSync <= 2'b11;
            sdaSync <= 2'b11;
        end else begin
            sclSync <= {sclSync[0], iScl};
            sdaSync <= {sdaSync[0], iSda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] sclHist;
    logic [1:0] sdaHist;
    logic       sclFlt;
    logic       sdaFlt;

    // Majority of the current and two previous samples; a 1-cycle pulse never wins.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            sclHist <= 2'b11;
            sdaHist <= 2'b11;
            sclFlt  <= 1'b1;
            sdaFlt  <= 1'b1;
        end else begin
            sclHist <= {sclHist[0], sclSync[1]};
            sdaHist <= {sdaHist[0], sdaSync[1]};
            sclFlt  <= maj3(sclSync[1], sclHist[0], sclHist[1]);
            sdaFlt  <= maj3(sdaSync[1], sdaHist[0], sdaHist[1]);
        end
    end

    assign sclLvl = sclFlt;
    assign sdaLvl = sdaFlt;
`else
    assign sclLvl = sclSync[1];
    assign sdaLvl = sdaSync[1];
`endif

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPrev <= sclLvl;
            sdaPrev <= sdaLvl;
        end
    end

    assign oSdaLvl  = sdaLvl;
    assign oSclRise = sclLvl & ~sclPrev;
    assign oSclFall = ~sclLvl & sclPrev;
    // SDA may only move while SCL is stable high for a START/STOP.
    assign oStart   = sclLvl & sclPrev & sdaPrev & ~sdaLvl;
    assign oStop    = sclLvl & sclPrev & ~sdaPrev & sdaLvl;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a pointer-addressed register file and a local host port.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN enables the line majority filter.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] pDevAdrs  = 7'h50,
    parameter int         pRegDepth = 16,
    localparam int        cAdrsW    = (pRegDepth > 1) ? $clog2(pRegDepth) : 1
) (
    input  logic              iSysClk,
    input  logic              iSysRst,
    input  logic              iScl,
    input  logic              iSda,
    output logic              oSdaOe,
    input  logic [cAdrsW-1:0] iHostAdrs,
    input  logic [7:0]        iHostWd,
    input  logic              iHostWe,
    output logic [7:0]        oHostRd,
    output logic              oWrStrb,
    output logic [cAdrsW-1:0] oWrAdrs,
    output logic              oBusy,
    output i2cState_t         oDbgState
);

    localparam logic [cAdrsW-1:0] cPtrOne = 1;

    logic sdaLvl;
    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;

    i2c_line_cond uLineCond (
        .iClk     (iSysClk),
        .iRstN    (iSysRst),
        .iScl     (iScl),
        .iSda     (iSda),
        .oSdaLvl  (sdaLvl),
        .oSclRise (sclRise),
        .oSclFall (sclFall),
        .oStart   (startDet),
        .oStop    (stopDet)
    );

    i2cState_t         state, stateNxt;
    logic [3:0]        bitCnt, bitCntNxt;
    logic [7:0]        shiftReg, shiftNxt;
    logic [cAdrsW-1:0] ptr, ptrNxt;
    logic              sdaOe, sdaOeNxt;
    logic              busy, busyNxt;
    logic              rwBit, rwNxt;
    logic              ackBit, ackNxt;
    logic              wrStrb, wrStrbNxt;
    logic [cAdrsW-1:0] wrAdrs, wrAdrsNxt;
    logic              regWe;
    logic [7:0]        regs [pRegDepth];
    logic [7:0]        curByte;
    logic [7:0]        hostRd;

    assign curByte = regs[ptr];

    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            state    <= IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            ptr      <= '0;
            sdaOe    <= 1'b0;
            busy     <= 1'b0;
            rwBit    <= 1'b0;
            ackBit   <= cNack;
            wrStrb   <= 1'b0;
            wrAdrs   <= '0;
        end else begin
            state    <= stateNxt;
            bitCnt   <= bitCntNxt;
            shiftReg <= shiftNxt;
            ptr      <= ptrNxt;
            sdaOe    <= sdaOeNxt;
            busy     <= busyNxt;
            rwBit    <= rwNxt;
            ackBit   <= ackNxt;
            wrStrb   <= wrStrbNxt;
            wrAdrs   <= wrAdrsNxt;
        end
    end

    // SDA is sampled on SCL rise; the target output only moves on SCL fall.
    always_comb begin
        stateNxt  = state;
        bitCntNxt = bitCnt;
        shiftNxt  = shiftReg;
        ptrNxt    = ptr;
        sdaOeNxt  = sdaOe;
        busyNxt   = busy;
        rwNxt     = rwBit;
        ackNxt    = ackBit;
        wrStrbNxt = 1'b0;
        wrAdrsNxt = wrAdrs;
        regWe     = 1'b0;

        if (stopDet) begin
            stateNxt = IDLE;
            sdaOeNxt = 1'b0;
            busyNxt  = 1'b0;
        end else if (startDet) begin
            stateNxt  = ADDR;
            bitCntNxt = '0;
            sdaOeNxt  = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (sclRise && bitCnt != 4'd8) begin
                        shiftNxt  = {shiftReg[6:0], sdaLvl};
                        bitCntNxt = bitCnt + 4'd1;
                    end else if (sclFall && bitCnt == 4'd8) begin
                        sdaOeNxt  = 1'b1;
                        bitCntNxt = '0;
                        if (state == ADDR) begin
                            if (shiftReg[7:1] == pDevAdrs) begin
                                rwNxt    = shiftReg[0];
                                busyNxt  = 1'b1;
                                stateNxt = ADDR_ACK;
                            end else begin
                                sdaOeNxt = 1'b0;
                                stateNxt = IDLE;
                            end
                        end else if (state == PTR) begin
                            ptrNxt   = shiftReg[cAdrsW-1:0];
                            stateNxt = PTR_ACK;
                        end else begin
                            regWe     = 1'b1;
                            wrStrbNxt = 1'b1;
                            wrAdrsNxt = ptr;
                            ptrNxt    = ptr + cPtrOne;
                            stateNxt  = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        bitCntNxt = '0;
                        if (rwBit) begin
                            shiftNxt = curByte;
                            sdaOeNxt = ~curByte[7];
                            stateNxt = RD_DATA;
                        end else begin
                            sdaOeNxt = 1'b0;
                            stateNxt = PTR;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (sclFall) begin
                        sdaOeNxt  = 1'b0;
                        bitCntNxt = '0;
                        stateNxt  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (sclRise && bitCnt != 4'd8) begin
                        bitCntNxt = bitCnt + 4'd1;
                    end else if (sclFall && bitCnt != 4'd0) begin
                        if (bitCnt == 4'd8) begin
                            sdaOeNxt  = 1'b0;
                            ptrNxt    = ptr + cPtrOne;
                            bitCntNxt = '0;
                            stateNxt  = RD_ACK;
                        end else begin
                            shiftNxt = {shiftReg[6:0], 1'b0};
                            sdaOeNxt = ~shiftReg[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (sclRise) begin
                        ackNxt = sdaLvl;
                    end else if (sclFall) begin
                        if (ackBit == cNack) begin
                            sdaOeNxt = 1'b0;
                            stateNxt = IDLE;
                        end else begin
                            shiftNxt  = curByte;
                            sdaOeNxt  = ~curByte[7];
                            bitCntNxt = '0;
                            stateNxt  = RD_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The I2C write is assigned last so it wins a same-cycle clash with the host.
    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            for (int i = 0; i < pRegDepth; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (iHostWe) begin
                regs[iHostAdrs] <= iHostWd;
            end
            if (regWe) begin
                regs[ptr] <= shiftReg;
            end
        end
    end

    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            hostRd <= '0;
        end else begin
            hostRd <= regs[iHostAdrs];
        end
    end

    assign oSdaOe    = sdaOe;
    assign oHostRd   = hostRd;
    assign oWrStrb   = wrStrb;
    assign oWrAdrs   = wrAdrs;
    assign oBusy     = busy;
    assign oDbgState = state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, register model and
// scoreboard queues for write strobes and read data.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int cQ = 8;

    logic       iSysClk = 1'b0;
    logic       iSysRst = 1'b0;
    logic       iScl;
    logic       iSda;
    logic       oSdaOe;
    logic [3:0] iHostAdrs = '0;
    logic [7:0] iHostWd = '0;
    logic       iHostWe = 1'b0;
    logic [7:0] oHostRd;
    logic       oWrStrb;
    logic [3:0] oWrAdrs;
    logic       oBusy;
    i2cState_t  oDbgState;

    logic sclDrv = 1'b1;
    logic sdaDrv = 1'b1;

    assign iScl = sclDrv;
    assign iSda = sdaDrv & ~oSdaOe;

    always #5 iSysClk = ~iSysClk;

    i2c_target #(.pDevAdrs(7'h50), .pRegDepth(16)) dut (
        .iSysClk   (iSysClk),
        .iSysRst   (iSysRst),
        .iScl      (iScl),
        .iSda      (iSda),
        .oSdaOe    (oSdaOe),
        .iHostAdrs (iHostAdrs),
        .iHostWd   (iHostWd),
        .iHostWe   (iHostWe),
        .oHostRd   (oHostRd),
        .oWrStrb   (oWrStrb),
        .oWrAdrs   (oWrAdrs),
        .oBusy     (oBusy),
        .oDbgState (oDbgState)
    );

    int nChecks = 0;
    int nErrors = 0;
    int oeHighCnt = 0;

    logic [3:0] strbExpQ[$];
    logic [7:0] rdExpQ[$];
    logic [7:0] refRegs [16];
    logic [3:0] refPtr = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge iSysClk);
        #1;
    endtask

    always @(negedge iSysClk) begin
        if (oSdaOe) oeHighCnt++;
    end

    // Write-strobe scoreboard: each pulse must match the oldest expected index.
    always @(negedge iSysClk) begin
        if (iSysRst && oWrStrb) begin
            if (strbExpQ.size() == 0) checkVal("wrStrbUnexpected", 32'(oWrAdrs), 32'hFFFF);
            else checkVal("wrAdrs", 32'(oWrAdrs), 32'(strbExpQ.pop_front()));
        end
    end

    task automatic busStart();
        sdaDrv = 1'b1; sclDrv = 1'b1; clks(cQ);
        sdaDrv = 1'b0; clks(cQ);
        sclDrv = 1'b0; clks(cQ);
    endtask

    task automatic busRepStart();
        sdaDrv = 1'b1; clks(cQ);
        sclDrv = 1'b1; clks(cQ);
        sdaDrv = 1'b0; clks(cQ);
        sclDrv = 1'b0; clks(cQ);
    endtask

    task automatic busStop();
        sdaDrv = 1'b0; clks(cQ);
        sclDrv = 1'b1; clks(cQ);
        sdaDrv = 1'b1; clks(cQ);
    endtask

    task automatic busBit(input logic b, output logic s);
        sdaDrv = b; clks(cQ);
        sclDrv = 1'b1; clks(cQ / 2);
        s = iSda; clks(cQ / 2);
        sclDrv = 1'b0; clks(cQ);
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) busBit(d[i], s);
        busBit(1'b1, ack);
    endtask

    task automatic recvByte(input logic ctrlAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) busBit(1'b1, d[i]);
        busBit(ctrlAck, s);
    endtask

    task automatic i2cWrData(input logic [7:0] d);
        logic ack;
        strbExpQ.push_back(refPtr);
        refRegs[refPtr] = d;
        refPtr++;
        sendByte(d, ack);
        checkVal("wrDataAck", 32'(ack), 32'(cAck));
    endtask

    task automatic i2cRdData(input logic ctrlAck);
        logic [7:0] d;
        rdExpQ.push_back(refRegs[refPtr]);
        refPtr++;
        recvByte(ctrlAck, d);
        if (rdExpQ.size() == 0) checkVal("rdDataUnexpected", 32'(d), 32'hFFFF);
        else checkVal("rdData", 32'(d), 32'(rdExpQ.pop_front()));
    endtask

    task automatic hostWrite(input logic [3:0] a, input logic [7:0] d);
        iHostAdrs = a; iHostWd = d; iHostWe = 1'b1;
        clks(1);
        iHostWe = 1'b0;
        refRegs[a] = d;
    endtask

    task automatic hostRead(input logic [3:0] a, output logic [7:0] d);
        iHostAdrs = a;
        clks(1);
        d = oHostRd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] v15, v0, v5;
        logic       seen;
        int         oeBase;

        for (int i = 0; i < 16; i++) refRegs[i] = '0;
        v15 = 8'($urandom_range(1, 127));
        v0  = v15 | 8'h80;
        v5  = 8'($urandom_range(1, 127));

        // Reset state.
        clks(5);
        checkVal("rstSdaOe", 32'(oSdaOe), 32'd0);
        checkVal("rstBusy", 32'(oBusy), 32'd0);
        checkVal("rstWrStrb", 32'(oWrStrb), 32'd0);
        checkVal("rstWrAdrs", 32'(oWrAdrs), 32'd0);
        checkVal("rstHostRd", 32'(oHostRd), 32'd0);
        checkVal("rstState", 32'(oDbgState), 32'(IDLE));
        iSysRst = 1'b1;
        clks(3);
        hostRead(4'd7, rd);
        checkVal("rstReg7", 32'(rd), 32'd0);

        // Pointer write then two data bytes.
        busStart();
        sendByte(8'hA0, ack);
        checkVal("t1AddrAck", 32'(ack), 32'(cAck));
        checkVal("t1BusyAfterAck", 32'(oBusy), 32'd1);
        sendByte(8'h03, ack);
        checkVal("t1PtrAck", 32'(ack), 32'(cAck));
        refPtr = 4'd3;
        i2cWrData(8'h5A);
        i2cWrData(8'hC3);
        checkVal("t1BusyBeforeStop", 32'(oBusy), 32'd1);
        busStop();
        checkVal("t1BusyAfterStop", 32'(oBusy), 32'd0);
        checkVal("t1StateAfterStop", 32'(oDbgState), 32'(IDLE));
        hostRead(4'd3, rd);
        checkVal("t1Reg3", 32'(rd), 32'(refRegs[3]));
        hostRead(4'd4, rd);
        checkVal("t1Reg4", 32'(rd), 32'(refRegs[4]));

        // Read across the top of the register file.
        hostWrite(4'd15, v15);
        hostWrite(4'd0, v0);
        busStart();
        sendByte(8'hA0, ack);
        checkVal("t2AddrAck", 32'(ack), 32'(cAck));
        sendByte(8'h0F, ack);
        checkVal("t2PtrAck", 32'(ack), 32'(cAck));
        refPtr = 4'd15;
        busRepStart();
        sendByte(8'hA1, ack);
        checkVal("t2RdAddrAck", 32'(ack), 32'(cAck));
        i2cRdData(cAck);
        i2cRdData(cNack);
        busStop();

        // Foreign address is ignored.
        oeBase = oeHighCnt;
        busStart();
        sendByte(8'hB0, ack);
        checkVal("t3NoAck", 32'(ack), 32'(cNack));
        checkVal("t3OeQuiet", 32'(oeHighCnt - oeBase), 32'd0);
        checkVal("t3State", 32'(oDbgState), 32'(IDLE));
        checkVal("t3Busy", 32'(oBusy), 32'd0);
        busStop();

        // Host and I2C write to reg[2] in the same cycle.
        busStart();
        sendByte(8'hA0, ack);
        checkVal("t4AddrAck", 32'(ack), 32'(cAck));
        sendByte(8'h02, ack);
        checkVal("t4PtrAck", 32'(ack), 32'(cAck));
        refPtr = 4'd2;
        seen = 1'b0;
        fork
            i2cWrData(8'h22);
            begin
                iHostAdrs = 4'd2; iHostWd = 8'h11; iHostWe = 1'b1;
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge iSysClk);
                    if (oWrStrb) seen = 1'b1;
                end
                iHostWe = 1'b0;
            end
        join
        checkVal("t4ClashSeen", 32'(seen), 32'd1);
        busStop();
        hostRead(4'd2, rd);
        checkVal("t4Reg2", 32'(rd), 32'h22);

        // Reset while the target drives a read bit low.
        hostWrite(4'd5, v5);
        busStart();
        sendByte(8'hA0, ack);
        sendByte(8'h05, ack);
        refPtr = 4'd5;
        busRepStart();
        sendByte(8'hA1, ack);
        checkVal("t5RdAddrAck", 32'(ack), 32'(cAck));
        checkVal("t5DriveLow", 32'(oSdaOe), 32'd1);
        iSysRst = 1'b0;
        clks(1);
        checkVal("t5RstRelease", 32'(oSdaOe), 32'd0);
        sclDrv = 1'b1;
        clks(4);
        iSysRst = 1'b1;
        for (int i = 0; i < 16; i++) refRegs[i] = '0;
        refPtr = '0;
        clks(cQ);
        checkVal("t5StateIdle", 32'(oDbgState), 32'(IDLE));
        hostWrite(4'd0, v0);
        busStart();
        sendByte(8'hA1, ack);
        checkVal("t5ReadAck", 32'(ack), 32'(cAck));
        i2cRdData(cNack);
        busStop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // A one-cycle SDA dip with SCL high must not look like START.
        sdaDrv = 1'b0;
        clks(1);
        sdaDrv = 1'b1;
        clks(cQ);
        checkVal("t6GlitchIdle", 32'(oDbgState), 32'(IDLE));
`endif

        checkVal("strbQEmpty", 32'(strbExpQ.size()), 32'd0);
        checkVal("rdQEmpty", 32'(rdExpQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
